// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds, sticky errors, any DEPTH.
// Define FIFO_SYNC_LEVEL_FWFT_EN for first-word fall-through read data; default is registered read data.
module fifo_sync_level #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  localparam int LW                = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  error_clear
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          write_accept, read_accept;

  assign full         = (level_q == FULL_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign write_accept = write_enable & ~full;
  assign read_accept  = read_enable & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Explicit wrap so DEPTH need not be a power of two.
    if (write_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (read_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({write_accept, read_accept})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Clear first so a same-cycle set event wins.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (error_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_enable & full) begin
      overflow_d = 1'b1;
    end
    if (read_enable & empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not cleared; reset only drops the pointers.
  always_ff @(posedge clk) begin
    if (!reset && write_accept) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

`ifdef FIFO_SYNC_LEVEL_FWFT_EN
  assign read_data = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (read_accept) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign read_data = rdata_q;
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Directed self-checking bench for fifo_sync_level: DEPTH=8 main instance plus a DEPTH=5 instance for wrap.
// Works in both the standard and FIFO_SYNC_LEVEL_FWFT_EN builds.
module tb_fifo_sync_level;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       we, re, eclr;
  logic [7:0] wd, rd;
  logic       full, empty, af, ae, ovf, udf;
  logic [3:0] level;

  logic       b_we, b_re;
  logic [7:0] b_wd, b_rd;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(rst),
    .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd),
    .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .level(level), .overflow(ovf), .underflow(udf), .error_clear(eclr)
  );

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset(rst),
    .write_enable(b_we), .write_data(b_wd),
    .read_enable(b_re), .read_data(b_rd),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .level(b_level), .overflow(b_ovf), .underflow(b_udf), .error_clear(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    we = 1'b1;
    wd = d;
    step();
    we = 1'b0;
    $display("push %02h level=%0d", d, level);
  endtask

  // Returns the popped word regardless of build.
  task automatic pop(output logic [7:0] d);
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
    d  = rd;
    re = 1'b1;
    step();
    re = 1'b0;
`else
    re = 1'b1;
    step();
    re = 1'b0;
    d  = rd;
`endif
    $display("pop  %02h level=%0d", d, level);
  endtask

  task automatic clear_errors();
    eclr = 1'b1;
    step();
    eclr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", ae); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", af); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_errors: got ovf=%b udf=%b want 0/0", ovf, udf); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %02h want 00", rd); end
    checks++; if (b_level !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL reset_d5: got level=%0d empty=%b want 0/1", b_level, b_empty); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] got;
    logic [3:0] exp_lvl;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      exp_lvl = 4'(i);
      checks++; if (level !== exp_lvl) begin errors++; $display("FAIL fill_level: got %0d want %0d", level, exp_lvl); end
      checks++; if (af !== (i >= 7)) begin errors++; $display("FAIL fill_almost_full: got %b want %b at level %0d", af, (i >= 7), i); end
      checks++; if (full !== (i == 8)) begin errors++; $display("FAIL fill_full: got %b want %b at level %0d", full, (i == 8), i); end
      checks++; if (ae !== (i <= 1)) begin errors++; $display("FAIL fill_almost_empty: got %b want %b at level %0d", ae, (i <= 1), i); end
    end
    for (int i = 1; i <= 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(i)) begin errors++; $display("FAIL drain_data: got %02h want %02h", got, 8'(i)); end
      exp_lvl = 4'(8 - i);
      checks++; if (level !== exp_lvl) begin errors++; $display("FAIL drain_level: got %0d want %0d", level, exp_lvl); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL drain_errors: got ovf=%b udf=%b want 0/0", ovf, udf); end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    for (int i = 1; i <= 8; i++) push(8'(i));
    we = 1'b1; wd = 8'hAA;
    step();
    we = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    step();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    we = 1'b1; wd = 8'hAB; eclr = 1'b1;
    step();
    we = 1'b0; eclr = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
    clear_errors();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    for (int i = 1; i <= 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(i)) begin errors++; $display("FAIL ovf_data: got %02h want %02h", got, 8'(i)); end
    end
    checks++; if (empty !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL ovf_end: got empty=%b udf=%b want 1/0", empty, udf); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got;
    for (int i = 1; i <= 8; i++) push(8'(i));
    we = 1'b1; re = 1'b1; wd = 8'h55;
    step();
    we = 1'b0; re = 1'b0;
    $display("push+pop 55 when full level=%0d", level);
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL simul_full_level: got %0d want 7", level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL simul_full_overflow: got %b want 1", ovf); end
    for (int i = 2; i <= 8; i++) begin
      pop(got);
      checks++; if (got !== 8'(i)) begin errors++; $display("FAIL simul_full_data: got %02h want %02h", got, 8'(i)); end
    end
    clear_errors();
    we = 1'b1; re = 1'b1; wd = 8'h33;
    step();
    we = 1'b0; re = 1'b0;
    $display("push+pop 33 when empty level=%0d", level);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL simul_empty_level: got %0d want 1", level); end
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL simul_empty_underflow: got %b want 1", udf); end
`ifndef FIFO_SYNC_LEVEL_FWFT_EN
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL simul_rejected_hold: got %02h want 08", rd); end
`endif
    pop(got);
    checks++; if (got !== 8'h33) begin errors++; $display("FAIL simul_empty_data: got %02h want 33", got); end
    clear_errors();
  endtask

  task automatic test_wrap_depth5();
    logic [7:0] got;
    int wi = 0;
    int ri = 0;
    for (int k = 0; k < 3; k++) begin
      b_we = 1'b1; b_wd = 8'(wi); wi++;
      step();
    end
    b_we = 1'b0;
    while (wi < 20) begin
      b_we = 1'b1; b_wd = 8'(wi); b_re = 1'b1;
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
      got = b_rd;
      step();
`else
      step();
      got = b_rd;
`endif
      $display("d5 push %02h pop %02h level=%0d", 8'(wi), got, b_level);
      checks++; if (got !== 8'(ri)) begin errors++; $display("FAIL wrap_data: got %02h want %02h", got, 8'(ri)); end
      checks++; if (b_level !== 3'd3) begin errors++; $display("FAIL wrap_level: got %0d want 3", b_level); end
      wi++; ri++;
    end
    b_we = 1'b0;
    while (ri < 20) begin
      b_re = 1'b1;
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
      got = b_rd;
      step();
`else
      step();
      got = b_rd;
`endif
      $display("d5 pop %02h level=%0d", got, b_level);
      checks++; if (got !== 8'(ri)) begin errors++; $display("FAIL wrap_drain_data: got %02h want %02h", got, 8'(ri)); end
      ri++;
    end
    b_re = 1'b0;
    checks++; if (b_empty !== 1'b1 || b_udf !== 1'b0 || b_ovf !== 1'b0) begin errors++; $display("FAIL wrap_end: got empty=%b udf=%b ovf=%b want 1/0/0", b_empty, b_udf, b_ovf); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    re = 1'b1;
    step();
    re = 1'b0;
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL mid_underflow_pre: got %b want 1", udf); end
    push(8'h11); push(8'h22); push(8'h33);
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL mid_level_pre: got %0d want 3", level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset mid-operation level=%0d", level);
    checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset_level: got level=%0d empty=%b want 0/1", level, empty); end
    checks++; if (udf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got ovf=%b udf=%b want 0/0", ovf, udf); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_reset_read_data: got %02h want 00", rd); end
    push(8'h7E);
    pop(got);
    checks++; if (got !== 8'h7E) begin errors++; $display("FAIL mid_post_data: got %02h want 7e", got); end
  endtask

  task automatic test_read_timing();
    push(8'h42);
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
    checks++; if (rd !== 8'h42) begin errors++; $display("FAIL fwft_visible: got %02h want 42", rd); end
    step();
    checks++; if (rd !== 8'h42 || level !== 4'd1) begin errors++; $display("FAIL fwft_stable: got %02h level=%0d want 42/1", rd, level); end
    re = 1'b1;
    step();
    re = 1'b0;
    checks++; if (rd !== 8'h00 || empty !== 1'b1) begin errors++; $display("FAIL fwft_empty_zero: got %02h empty=%b want 00/1", rd, empty); end
`else
    checks++; if (rd !== 8'h7E) begin errors++; $display("FAIL std_before_read: got %02h want 7e", rd); end
    re = 1'b1;
    step();
    re = 1'b0;
    checks++; if (rd !== 8'h42) begin errors++; $display("FAIL std_after_read: got %02h want 42", rd); end
    step();
    checks++; if (rd !== 8'h42) begin errors++; $display("FAIL std_hold: got %02h want 42", rd); end
`endif
    re = 1'b1;
    step();
    re = 1'b0;
    $display("rejected pop read_data=%02h underflow=%b", rd, udf);
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL fwft_rejected: got %02h want 00", rd); end
`else
    checks++; if (rd !== 8'h42) begin errors++; $display("FAIL std_rejected_hold: got %02h want 42", rd); end
`endif
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL timing_underflow: got %b want 1", udf); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; eclr = 1'b0; wd = 8'h00;
    b_we = 1'b0; b_re = 1'b0; b_wd = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap_depth5();
    test_reset_mid();
    test_read_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
